// File: rtl/eep_pkg.sv
// Shared definitions for the SPI calibration EEPROM model.
//   - Geometry defaults (address/data width, frame length).
//   - Opcode encodings carried in the top two frame bits.
//   - FSM state encoding for the frame engine.
package eep_pkg;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 16;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } eep_state_e;

endpackage

// File: rtl/spi_eep_sync.sv
// Three-flop synchroniser with edge detection for one asynchronous pin.
//   clk   : system clock
//   rst_n : synchronous reset, active high
//   din   : asynchronous input pin
//   sync  : synchronised level (second flop)
//   rise  : one-clk pulse on a synchronised 0->1 transition
//   fall  : one-clk pulse on a synchronised 1->0 transition
// RST_VAL is the idle level of the pin, so leaving reset with the pin idle
// produces no spurious edge.
module spi_eep_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_eep_model.sv
// Behavioural calibration EEPROM answering as an SPI slave (mode 0, MSB first).
// Frame: [15:14] opcode, [13:8] address, [7:0] data.
//   opcode 01 writes data to mem[address] when exactly 16 bits were clocked.
//   opcode 00 returns mem[address] on MISO during the data byte of the frame.
//   other opcodes are ignored.
// Ports:
//   clk   : system clock, all logic on the rising edge
//   rst_n : synchronous reset, active HIGH (name inherited from the codebase)
//   SS_n  : slave select, active low, asynchronous
//   SCLK  : SPI clock, idles low, asynchronous, much slower than clk
//   MOSI  : serial data in
//   MISO  : serial data out (0 whenever no read data is being returned)
// The FSM state is held in the signal 'state' for external checkers.
module spi_eep_model
  import eep_pkg::*;
#(
  parameter int ADDR_W     = eep_pkg::ADDR_W,
  parameter int DATA_W     = eep_pkg::DATA_W,
  parameter int FRAME_BITS = eep_pkg::FRAME_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);

  localparam int CNT_W    = $clog2(FRAME_BITS + 2);
  localparam int HDR_BITS = 2 + ADDR_W;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_PRE_H = CNT_W'(HDR_BITS - 1);

  // Synchronised pins and edges
  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_eep_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .din(SS_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );
  spi_eep_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(SCLK),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_eep_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(MOSI),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_sync, mosi_rise, mosi_fall};

  // Non-volatile array: never reset, powers up to all zeros.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Frame engine registers
  eep_state_e            state, state_d;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
  logic [FRAME_BITS-1:0] rx_shift, rx_shift_d;
  logic [DATA_W-1:0]     tx_shift, tx_shift_d;
  logic                  rd_act, rd_act_d;
  logic                  miso_q, miso_d;
  logic                  wr_en;

  // Leaving reset with SS_n already low would look like a fresh ss_fall once
  // the synchroniser flushes. Frames are only accepted after SS_n has been
  // seen high following reset, so an in-progress frame is ignored.
  logic [1:0] flush_cnt;
  logic       armed;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      flush_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
      if (flush_cnt == 2'd3 && ss_sync) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      rd_act   <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      rx_shift <= rx_shift_d;
      tx_shift <= tx_shift_d;
      rd_act   <= rd_act_d;
      miso_q   <= miso_d;
    end
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    rx_shift_d = rx_shift;
    tx_shift_d = tx_shift;
    rd_act_d   = rd_act;
    miso_d     = miso_q;
    wr_en      = 1'b0;

    unique case (state)
      IDLE: begin
        miso_d = 1'b0;
        if (armed && ss_fall) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
          rd_act_d   = 1'b0;
        end
      end

      SHIFT: begin
        // ss_rise takes priority over any SCLK edge in the same clk.
        if (ss_rise) begin
          state_d = DONE;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift[FRAME_BITS-2:0], mosi_sync};
          if (bit_cnt != CNT_MAX) bit_cnt_d = bit_cnt + 1'b1;
          // Header complete: opcode and address sit in the low bits now.
          if (bit_cnt == CNT_PRE_H &&
              rx_shift_d[HDR_BITS-1 -: 2] == OP_RD) begin
            tx_shift_d = mem[rx_shift_d[ADDR_W-1:0]];
            rd_act_d   = 1'b1;
          end
        end else if (sclk_fall && rd_act) begin
          miso_d     = tx_shift[DATA_W-1];
          tx_shift_d = {tx_shift[DATA_W-2:0], 1'b0};
        end
      end

      DONE: begin
        state_d    = IDLE;
        miso_d     = 1'b0;
        tx_shift_d = '0;
        rd_act_d   = 1'b0;
        wr_en      = (bit_cnt == CNT_FULL) &&
                     (rx_shift[FRAME_BITS-1 -: 2] == OP_WR);
      end

      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[rx_shift[DATA_W +: ADDR_W]] <= rx_shift[DATA_W-1:0];
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_spi_eep_model.sv
// Directed bench for spi_eep_model. A bit-banged SPI master drives frames;
// each frame's captured MISO word is handed to a monitor that compares it
// against the expectation queued when the frame was issued.
module tb_spi_eep_model;

  localparam int HALF = 6;  // SCLK half period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ss_n = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic miso;

  always #5 clk = ~clk;

  spi_eep_model dut (
    .clk  (clk),
    .rst_n(rst),
    .SS_n (ss_n),
    .SCLK (sclk),
    .MOSI (mosi),
    .MISO (miso)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [15:0] pres_data;
  int          pres_cnt = 0;
  int          vectors  = 0;
  int          fails    = 0;

  always @(pres_cnt) begin
    if (pres_cnt != 0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h, no expectation queued", pres_data);
      end else begin
        logic [15:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (pres_data !== e) begin
          fails++;
          $display("FAIL %s: got %h, expected %h", n, pres_data, e);
        end
      end
    end
  end

  // MISO must be 0 once SS_n has been high for a few clocks.
  int ss_hi_cnt = 0;
  int idle_bad  = 0;
  always @(negedge clk) begin
    if (ss_n) ss_hi_cnt <= ss_hi_cnt + 1;
    else      ss_hi_cnt <= 0;
    if (ss_n && ss_hi_cnt >= 5 && miso !== 1'b0) idle_bad <= idle_bad + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic expect_word(input string n, input logic [15:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic present(input logic [15:0] v);
    pres_data = v;
    pres_cnt++;
  endtask

  // Clock out nbits of w (zeros past bit 16); capture MISO at each rise.
  task automatic shift_bits(input logic [15:0] w, input int nbits,
                            output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 16) cap[15-i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input string n, input logic [15:0] w, input int nbits,
                       input logic [15:0] e, input int gap);
    logic [15:0] cap;
    expect_word(n, e);
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(w, nbits, cap);
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    present(cap);
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] cap;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    expect_word("reset_miso", 16'h0000);
    present({15'b0, miso});
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Write then read
    frame("wr_12",      {2'b01, 6'h12, 8'h34}, 16, 16'h0000, 8);
    frame("rd_12",      {2'b00, 6'h12, 8'h00}, 16, 16'h0034, 8);

    // Short frame: no write
    frame("short_wr",   {2'b01, 6'h05, 8'hAA}, 12, 16'h0000, 8);
    frame("rd_05",      {2'b00, 6'h05, 8'h00}, 16, 16'h0000, 8);

    // Overlong frame: no write
    frame("long_wr",    {2'b01, 6'h3F, 8'h77}, 17, 16'h0000, 8);
    frame("rd_3f_long", {2'b00, 6'h3F, 8'h00}, 16, 16'h0000, 8);

    // Preload 01, then reset in the middle of an overwriting frame
    frame("wr_01",      {2'b01, 6'h01, 8'h5A}, 16, 16'h0000, 8);
    expect_word("rst_mid_miso", 16'h0000);
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits({2'b01, 6'h01, 8'hC3}, 10, cap);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    present({15'b0, miso});
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
    frame("rd_01",      {2'b00, 6'h01, 8'h00}, 16, 16'h005A, 8);

    // Ignored opcode, then SCLK activity with SS_n high
    frame("op11",       {2'b11, 6'h02, 8'hFF}, 16, 16'h0000, 8);
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    frame("rd_02",      {2'b00, 6'h02, 8'h00}, 16, 16'h0000, 8);
    frame("rd_12_again",{2'b00, 6'h12, 8'h00}, 16, 16'h0034, 8);

    // Back-to-back with 2 clk SS_n-high gaps
    frame("b2b_wr_00",  {2'b01, 6'h00, 8'h11}, 16, 16'h0000, 1);
    frame("b2b_wr_3f",  {2'b01, 6'h3F, 8'hEE}, 16, 16'h0000, 1);
    frame("b2b_rd_00",  {2'b00, 6'h00, 8'h00}, 16, 16'h0011, 1);
    frame("b2b_rd_3f",  {2'b00, 6'h3F, 8'h00}, 16, 16'h00EE, 8);
    // Unrelated entries unaffected
    frame("rd_01_final",{2'b00, 6'h01, 8'h00}, 16, 16'h005A, 8);

    repeat (10) @(negedge clk);

    vectors++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_expect: got %0d left over, expected 0", exp_q.size());
    end
    vectors++;
    if (idle_bad != 0) begin
      fails++;
      $display("FAIL idle_miso: got %0d nonzero idle samples, expected 0", idle_bad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_eep_model.md
Name: spi_eep_model

Overview:
- Behavioural calibration EEPROM that responds as an SPI slave on the DSO_dig SPI bus (shared MOSI/SCLK, dedicated EEP_ss_n).
- Stores 64 x 8-bit calibration values. DSO_dig writes entries (host cmd 08 aaaaaa VV) and reads them back (host read-EEP cmd).
- Oversamples the SPI pins with the system clock. SCLK is much slower than clk.

Parameters:
ADDR_W, 6, address width (64 entries)
DATA_W, 8, data width
FRAME_BITS, 16, bits per SPI frame

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-high despite the _n suffix (name kept per codebase)
SS_n  input  1  slave select, active low, asynchronous to clk
SCLK  input  1  SPI clock, mode 0, idles low, asynchronous
MOSI  input  1  serial data in, MSB first
MISO  output  1  serial data out, MSB first

Behaviour:
- Synchronisation: SS_n, SCLK and MOSI each pass through a 2-flop synchroniser, plus a third flop for edge detect.
  - sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3.
  - ss_fall and ss_rise are derived the same way.
- Frame format, MSB first, 16 bits: [15:14] opcode, [13:8] addr, [7:0] data.
  - 2'b01 = write.
  - 2'b00 = read.
  - 2'b10 and 2'b11 are ignored (no write, MISO stays 0).
- States: IDLE, SHIFT, DONE.
  - IDLE --ss_fall--> SHIFT. On entry, bit_cnt := 0, rx_shift := 0.
  - SHIFT: on sclk_rise, rx_shift := {rx_shift[14:0], MOSI_sync}; bit_cnt++ (saturates at 17).
  - SHIFT --ss_rise--> DONE. DONE lasts one clk.
    - If bit_cnt == 16 and opcode == 01, then mem[addr] := data.
    - Any other count discards the frame.
  - DONE -> IDLE.
- Read path:
  - When bit_cnt becomes 8 in SHIFT and rx_shift[7:6] == 00, load tx_shift := mem[rx_shift[5:0]].
  - On each following sclk_fall, MISO := tx_shift[7] and tx_shift shifts left, filling with 0.
  - The data byte therefore appears in bits 7..0 of the same frame, sampled by the master on SCLK rise.
- MISO is 0 in IDLE/DONE, during the first 8 bits, and for non-read opcodes.
- Write latency: mem updates on the clk edge ending DONE, which is 4 clk after the EEP_ss_n pin rises. A read frame started after that sees the new value.
- Reset (rst_n == 1):
  - state := IDLE, bit_cnt := 0, rx_shift := 0, tx_shift := 0, MISO := 0, synchroniser flops := SS_n-high/SCLK-low idle values.
  - mem is NOT cleared (non-volatile). Memory powers up to all 8'h00.
- Reset mid-frame: the frame is abandoned. A new frame requires a fresh ss_fall; a frame in progress while reset deasserts is ignored.
- Simultaneous ss_rise and an SCLK edge in the same clk: ss_rise wins and the SCLK edge is ignored.
- More than 16 SCLK rises in a frame: the frame is invalid and no write occurs.
- Fewer than 8 bits: no read data is driven.
- SCLK edges while SS_n is high are ignored.

Decomposition:
- Shared package eep_pkg:
  - opcode constants OP_RD = 2'b00, OP_WR = 2'b01.
  - state enum {IDLE, SHIFT, DONE}.
  - ADDR_W/DATA_W defaults.
- One sub-module: spi_eep_sync. It is a 3-flop synchroniser plus rise/fall detector, instantiated three times.
- The memory array is inline.

Test Plan:
- Write then read: frame {01, 6'h12, 8'h34}, then frame {00, 6'h12, 8'h00}.
  - Required: MISO bits 7..0 of the read frame equal 8'h34.
  - Required: mem[6'h12] == 8'h34.
- Short frame: 12 SCLK pulses of {01, 6'h05, 8'hAA}, then SS_n high.
  - Required: mem[6'h05] unchanged (8'h00). The next read of 6'h05 returns 8'h00.
- Overlong frame: 17 SCLK pulses with opcode 01, addr 6'h3F.
  - Required: no write. A read of 6'h3F returns 8'h00.
- Reset mid-frame: assert rst_n after 10 bits of a write to 6'h01, deassert, raise SS_n.
  - Required: no write; MISO == 0.
  - Required: a preloaded mem[6'h01] == 8'h5A survives the reset.
- Idle/ignored opcode: frame {11, 6'h02, 8'hFF} and SCLK toggling with SS_n high.
  - Required: MISO stays 0 throughout and no memory changes.
- Back-to-back: write 6'h00 = 8'h11, write 6'h3F = 8'hEE, read 6'h00 and read 6'h3F.
  - Required: reads return 8'h11 and 8'hEE with 2 clk SS_n-high gaps between frames.
